// File: rtl/mod_n_stream_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mod_n_pkg
// Description : Shared types and the residue-step helper for mod_n_stream_div.
//               Macro BCD_CHECK_EN selects radix-10 BCD digits.
// Revision    : 1.0 - initial release
// ============================================================================
package mod_n_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    RESULT = 2'd2
  } state_t;

  localparam int DIGIT_W_MAX = 16;
  localparam int DIVISOR_MAX = 255;

  function automatic int radix_of(input int digit_w);
`ifdef BCD_CHECK_EN
    return 10;
`else
    return 1 << digit_w;
`endif
  endfunction

  localparam int RADIX = radix_of(4);

  // Holds r*RADIX + d for any legal divisor and digit width without truncation
  localparam int PROD_W = $clog2(DIVISOR_MAX * (1 << DIGIT_W_MAX));

  function automatic logic [PROD_W-1:0] mod_step(
    input logic [PROD_W-1:0] r,
    input logic [PROD_W-1:0] d,
    input logic [PROD_W-1:0] radix,
    input logic [PROD_W-1:0] divisor
  );
    logic [PROD_W-1:0] w_wide;
    w_wide = r * radix + d;
    return w_wide % divisor;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_n_stream_div_step.sv
`default_nettype none
// ============================================================================
// Module      : mod_n_step
// Description : Combinational residue reducer, r_next = (r*RADIX + d) mod DIVISOR.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_n_step
  import mod_n_pkg::*;
#(
  parameter int DIVISOR = 3,
  parameter int RADIX   = 16,
  parameter int DIGIT_W = 4,
  parameter int RES_W   = 8
) (
  input  logic [RES_W-1:0]   i_r,
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [RES_W-1:0]   o_r_next
);

  // Radix and divisor are elaboration constants, so the modulo folds to fixed logic
  assign o_r_next = RES_W'(mod_step(PROD_W'(i_r), PROD_W'(i_digit),
                                    PROD_W'(RADIX), PROD_W'(DIVISOR)));

endmodule
`default_nettype wire

// File: rtl/mod_n_stream_div.sv
`default_nettype none
// ============================================================================
// Module      : mod_n_stream_div
// Description : Streaming MSD-first divisibility checker with valid/ready/last.
//               Optional BCD digit checking under macro BCD_CHECK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mod_n_stream_div
  import mod_n_pkg::*;
#(
  parameter int DIGIT_W = 4,
  parameter int DIVISOR = 3,
  parameter int RES_W   = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DIGIT_W-1:0] in_digit,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_div,
  output logic [RES_W-1:0]   out_residue,
  output logic [CNT_W-1:0]   out_count,
  output logic               out_err
);

  localparam int c_RADIX = radix_of(DIGIT_W);

  if (DIVISOR < 2 || DIVISOR > DIVISOR_MAX) begin : g_bad_divisor
    $error("DIVISOR out of range 2..255");
  end
  if ((1 << RES_W) < DIVISOR) begin : g_bad_res_w
    $error("RES_W too narrow for DIVISOR");
  end
  if (DIGIT_W > DIGIT_W_MAX) begin : g_bad_digit_w
    $error("DIGIT_W too wide");
  end
`ifdef BCD_CHECK_EN
  if (DIGIT_W != 4) begin : g_bad_bcd_w
    $error("BCD digits require DIGIT_W == 4");
  end
`endif

  state_t             r_state, w_state_nxt;
  logic               w_beat;
  logic [RES_W-1:0]   r_res, w_r_base, w_r_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_base, w_cnt_nxt;
  logic [DIGIT_W-1:0] w_digit_eff;
  logic               w_err_nxt;
  logic [RES_W-1:0]   r_out_res;
  logic               r_out_div;
  logic [CNT_W-1:0]   r_out_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE, ACCUM: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = in_last ? RESULT : ACCUM;
      end
      RESULT: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_beat = in_valid & in_ready;

  // A new number starts from zero residue and zero count
  assign w_r_base   = (r_state == IDLE) ? '0 : r_res;
  assign w_cnt_base = (r_state == IDLE) ? '0 : r_cnt;
  assign w_cnt_nxt  = (w_cnt_base == {CNT_W{1'b1}}) ? w_cnt_base : w_cnt_base + 1'b1;

`ifdef BCD_CHECK_EN
  logic r_err, r_out_err, w_bad;

  assign w_bad       = (in_digit > DIGIT_W'(9));
  assign w_digit_eff = w_bad ? '0 : in_digit;
  assign w_err_nxt   = ((r_state == IDLE) ? 1'b0 : r_err) | w_bad;
  assign out_err     = r_out_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_out_err <= 1'b0;
    end else if (w_beat) begin
      r_err <= w_err_nxt;
      if (in_last) r_out_err <= w_err_nxt;
    end else if (r_state == RESULT && out_ready) begin
      r_err <= 1'b0;
    end
  end
`else
  assign w_digit_eff = in_digit;
  assign w_err_nxt   = 1'b0;
  assign out_err     = 1'b0;
`endif

  mod_n_step #(
    .DIVISOR (DIVISOR),
    .RADIX   (c_RADIX),
    .DIGIT_W (DIGIT_W),
    .RES_W   (RES_W)
  ) u_step (
    .i_r      (w_r_base),
    .i_digit  (w_digit_eff),
    .o_r_next (w_r_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_res     <= '0;
      r_cnt     <= '0;
      r_out_res <= '0;
      r_out_div <= 1'b0;
      r_out_cnt <= '0;
    end else if (w_beat) begin
      r_res <= w_r_next;
      r_cnt <= w_cnt_nxt;
      if (in_last) begin
        r_out_res <= w_r_next;
        r_out_div <= (w_r_next == '0) & ~w_err_nxt;
        r_out_cnt <= w_cnt_nxt;
      end
    end else if (r_state == RESULT && out_ready) begin
      r_res <= '0;
      r_cnt <= '0;
    end
  end

  assign out_residue = r_out_res;
  assign out_div     = r_out_div;
  assign out_count   = r_out_cnt;

endmodule
`default_nettype wire

// File: tb/tb_mod_n_stream_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_mod_n_stream_div
// Description : Scoreboard bench; DIVISOR=3 and DIVISOR=7 instances share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mod_n_stream_div;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_last, out_ready;
  logic [3:0] in_digit;
  logic       in_ready, out_valid, out_div, out_err;
  logic [7:0] out_residue, out_count;
  logic       in_ready7, out_valid7, out_div7, out_err7;
  logic [7:0] out_residue7, out_count7;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int r3;
    int r7;
    int cnt;
    bit err;
  } exp_t;

  exp_t       sb[$];
  exp_t       e;
  logic [3:0] digs [300];

  always #5 clk = ~clk;

  mod_n_stream_div #(.DIGIT_W(4), .DIVISOR(3), .RES_W(8), .CNT_W(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_digit(in_digit), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_div(out_div), .out_residue(out_residue),
    .out_count(out_count), .out_err(out_err)
  );

  mod_n_stream_div #(.DIGIT_W(4), .DIVISOR(7), .RES_W(8), .CNT_W(8)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready7),
    .in_digit(in_digit), .in_last(in_last), .out_valid(out_valid7),
    .out_ready(out_ready), .out_div(out_div7), .out_residue(out_residue7),
    .out_count(out_count7), .out_err(out_err7)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Consumer side: a result is taken on the edge following a negedge with valid & ready
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      check_eq("result_expected", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check_eq("residue3", out_residue, e.r3);
        check_eq("div3", out_div, (e.r3 == 0) && !e.err);
        check_eq("count3", out_count, e.cnt);
        check_eq("err3", out_err, e.err);
        check_eq("valid7", out_valid7, 1);
        check_eq("residue7", out_residue7, e.r7);
        check_eq("div7", out_div7, (e.r7 == 0) && !e.err);
        check_eq("count7", out_count7, e.cnt);
      end
    end
  end

  task automatic drive_beat(input logic [3:0] d, input logic last);
    logic rdy;
    int   guard;
    in_valid = 1'b1;
    in_digit = d;
    in_last  = last;
    guard    = 0;
    do begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!rdy && guard < 100);
    if (!rdy) check_eq("beat_timeout", rdy, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_num(input int n, input int gap);
    exp_t x;
    int   d, radix;
`ifdef BCD_CHECK_EN
    radix = 10;
`else
    radix = 16;
`endif
    x.r3 = 0; x.r7 = 0; x.err = 1'b0;
    for (int i = 0; i < n; i++) begin
      d = int'(digs[i]);
`ifdef BCD_CHECK_EN
      if (d > 9) begin
        x.err = 1'b1;
        d = 0;
      end
`endif
      x.r3 = (x.r3 * radix + d) % 3;
      x.r7 = (x.r7 * radix + d) % 7;
    end
    x.cnt = (n > 255) ? 255 : n;
    sb.push_back(x);
    for (int i = 0; i < n; i++) begin
      drive_beat(digs[i], i == n - 1);
      if (i == 0 && n > 1) repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    @(negedge clk);
    check_eq("latency_valid", out_valid, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_digit = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_residue", out_residue, 0);
    check_eq("rst_count", out_count, 0);
    check_eq("rst_div", out_div, 0);
    check_eq("rst_err", out_err, 0);
    @(posedge clk);
    #1;

    digs[0] = 4'h1; digs[1] = 4'h2; send_num(2, 0);
    digs[0] = 4'h7; send_num(1, 0);
    digs[0] = 4'hF; digs[1] = 4'hF; send_num(2, 0);

    // Result held under backpressure while a digit waits at the input
    out_ready = 1'b0;
    digs[0] = 4'h5; digs[1] = 4'h4; send_num(2, 0);
    in_valid = 1'b1; in_digit = 4'h3; in_last = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_eq("bp_in_ready", in_ready, 0);
      check_eq("bp_out_valid", out_valid, 1);
      check_eq("bp_residue", out_residue, sb[0].r3);
      check_eq("bp_count", out_count, sb[0].cnt);
      check_eq("bp_residue7", out_residue7, sb[0].r7);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    digs[0] = 4'h1; digs[1] = 4'h0; digs[2] = 4'h5; send_num(3, 3);

    // Abort a number with reset; only the following number may produce a result
    drive_beat(4'h4, 1'b0);
    drive_beat(4'h4, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    digs[0] = 4'h9; send_num(1, 0);

    digs[0] = 4'h1; digs[1] = 4'h2; digs[2] = 4'h3; send_num(3, 0);
    digs[0] = 4'h1; digs[1] = 4'hA; send_num(2, 0);

    for (int i = 0; i < 260; i++) digs[i] = 4'((i * 7 + 3) % 16);
    send_num(260, 0);

    for (int k = 0; k < 6; k++) begin
      int n;
      n = int'($urandom_range(1, 8));
      for (int i = 0; i < n; i++) digs[i] = 4'($urandom_range(0, 15));
      send_num(n, int'($urandom_range(0, 2)));
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("scoreboard_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mod_n_stream_div.md
Name: mod_n_stream_div

Overview:
- Streaming divisibility checker, generalised from the fixed 4-digit divide-by-3 combinational check.
- Accepts an arbitrary-length number as a stream of DIGIT_W-bit digits, most significant digit first, with a valid/ready/last handshake.
- Keeps a running residue modulo DIVISOR and returns one result per number: divisible flag, residue and digit count.
- Sits between the lab's digit-entry/UART front end and the display/result logic.

Parameters:
- DIGIT_W, 4: digit width in bits; radix = 2^DIGIT_W (see Optional Feature).
- DIVISOR, 3: modulus, 2..255.
- RES_W, 8: residue width; must satisfy 2^RES_W >= DIVISOR.
- CNT_W, 8: digit-counter width; the counter saturates.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous reset, active-low.
- in_valid  in  1  digit present.
- in_ready  out  1  block accepts digit.
- in_digit  in  DIGIT_W  digit value, MSD first.
- in_last  in  1  marks least significant (final) digit of the number.
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes result.
- out_div  out  1  1 when residue == 0.
- out_residue  out  RES_W  number mod DIVISOR.
- out_count  out  CNT_W  digits in the number, saturating at 2^CNT_W-1.
- out_err  out  1  digit error (only with BCD_CHECK_EN; tied 0 otherwise).

Behaviour:
- Reset: while rst_n=0 at a rising edge, go to IDLE; res=0, cnt=0, err=0, out_valid=0, out_div=0, out_residue=0, out_count=0, out_err=0. in_ready reads 1 after reset.
- Beat: an input beat is accepted when in_valid & in_ready at a clock edge.
- Residue step: r_next = (r*RADIX + in_digit) mod DIVISOR, with r=0 for the first digit of a number.
  - Computed at full width ceil(log2(DIVISOR*RADIX)) bits with no truncation.
  - Implemented as a constant reduction; no runtime divider.
- FSM states IDLE, ACCUM, RESULT:
  - IDLE: in_ready=1. Beat with in_last=0 -> ACCUM (res=r_next, cnt=1). Beat with in_last=1 -> RESULT.
  - ACCUM: in_ready=1. Each beat updates res and increments cnt, saturating. A beat with in_last=1 -> RESULT.
  - RESULT: in_ready=0, out_valid=1; outputs are registered and stay stable. When out_ready=1 at an edge -> IDLE, out_valid=0 next cycle, internal res/cnt/err cleared.
- Latency: out_valid rises on the clock edge that accepts the in_last beat, i.e. it is visible the cycle after that beat. Throughput is one digit per cycle. Minimum 1 bubble cycle between numbers (the RESULT cycle).
- in_valid=0 in ACCUM: hold state; gaps between digits are legal.
- Output registers: out_residue, out_div, out_count and out_err are loaded only when entering RESULT and hold their value in IDLE/ACCUM. out_valid alone qualifies them.
- Count saturation: at 2^CNT_W-1 the counter stays there; the residue is still exact.
- Reset mid-number or in RESULT: the number is discarded immediately; no result is emitted.
- in_digit, in_last: don't-care when in_valid=0.

Optional Feature:
- Macro: BCD_CHECK_EN.
- Defined:
  - Digits are BCD; radix 10, so r_next = (10*r + d) mod DIVISOR. DIGIT_W must be 4 (compile-time check).
  - A digit > 9 sets the sticky err flag for the current number. That digit is treated as 0 in the residue.
  - out_err=1 is reported with the result, and out_div is forced to 0.
- Undefined: radix 2^DIGIT_W; out_err is tied 0; no digit checking.

Decomposition:
- Package mod_n_pkg:
  - state enum {IDLE, ACCUM, RESULT};
  - function mod_step(r, d) returning the reduced residue;
  - localparam RADIX;
  - localparam for the width of the intermediate product.
- Sub-module mod_n_step: combinational residue reducer (r, digit -> r_next), parametrised by DIVISOR/RADIX. It is reused by later multi-channel versions.

Test Plan (DIVISOR=3, DIGIT_W=4 unless noted):
- Two-digit divisible: digits 0x1, 0x2+last (=18), out_ready=1 -> one cycle later out_valid=1, out_div=1, out_residue=0, out_count=2.
- Single digit: 0x7+last -> out_residue=1, out_div=0, out_count=1; then 0xF,0xF+last (=255) -> out_div=1.
- Backpressure: result pending, out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0 and outputs stable throughout; out_ready=1 -> IDLE, next number accepted.
- Gaps and modulus: DIVISOR=7, digits 0x1, gap 3 cycles, 0x0, 0x5+last (=0x105=261) -> out_residue=2, out_div=0.
- Reset mid-number: 0x4, 0x4, rst_n=0 one cycle, then 0x9+last -> out_residue=0, out_count=1; no result for the aborted number.
- BCD_CHECK_EN: digits 1,2,3+last -> out_div=1, out_count=3; digits 1,0xA+last -> out_err=1, out_div=0.
